// File: rtl/block_decoder_if.sv
// Receive-side bus between the descrambler/PCS chain and the 64B/66B block decoder.
// The decoder takes the slave modport; the block source and MAC side take master.
interface block_decoder_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 en;
    logic [65:0]          block_in;
    logic                 clr_count;
    logic [63:0]          data_out;
    logic [7:0]           valid_bytes;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en, block_in, clr_count,
        input  data_out, valid_bytes, err, err_count
    );

    modport slave (
        input  en, block_in, clr_count,
        output data_out, valid_bytes, err, err_count
    );
endinterface

// File: rtl/block_decoder.sv
// 64B/66B block decoder for the 40GBASE-R receive path: maps code blocks back to a
// byte stream with per-byte valid mask, tracks frame state and counts error blocks.
module block_decoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    block_decoder_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        K_IDLE,
        K_START,
        K_TERM,
        K_DATA,
        K_BAD
    } kind_e;

    state_e               state_q, state_d;
    logic [63:0]          data_out_q, data_out_d;
    logic [7:0]           valid_bytes_q, valid_bytes_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    kind_e       kind;
    logic [3:0]  term_n;
    logic [55:0] payload;
    logic        blk_err;

    assign payload = bus.block_in[65:10];

    // Classify the incoming block; term_n is the number of data bytes a terminate carries.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        kind   = K_BAD;
        term_n = 4'd0;
        unique case (bus.block_in[1:0])
            2'b10: kind = K_DATA;
            2'b01: begin
                unique case (bus.block_in[9:2])
                    8'h78: kind = K_IDLE;
                    8'h1E: kind = K_START;
                    8'hE1: begin kind = K_TERM; term_n = 4'd0; end
                    8'h99: begin kind = K_TERM; term_n = 4'd1; end
                    8'h55: begin kind = K_TERM; term_n = 4'd2; end
                    8'h2D: begin kind = K_TERM; term_n = 4'd3; end
                    8'h33: begin kind = K_TERM; term_n = 4'd4; end
                    8'h4B: begin kind = K_TERM; term_n = 4'd5; end
                    8'h87: begin kind = K_TERM; term_n = 4'd6; end
                    8'hFF: begin kind = K_TERM; term_n = 4'd7; end
                    default: kind = K_BAD;
                endcase
            end
            default: kind = K_BAD;
        endcase
    end

    assign blk_err = (kind == K_BAD)
                  || (kind == K_DATA  && state_q == IDLE)
                  || (kind == K_TERM  && state_q == IDLE)
                  || (kind == K_START && state_q == DATA);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            data_out_q    <= '0;
            valid_bytes_q <= '0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops
            // sample the pre-edge values regardless of statement order.
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            valid_bytes_q <= valid_bytes_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    // Next-state logic: any error drops back to IDLE, so a rejected start never opens a frame.
    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            if (blk_err) begin
                state_d = IDLE;
            end else begin
                unique case (kind)
                    K_START: state_d = DATA;
                    K_TERM:  state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Output logic (registered next-values)
    always_comb begin
        data_out_d    = data_out_q;
        valid_bytes_d = valid_bytes_q;
        err_d         = err_q;
        if (bus.en) begin
            data_out_d    = '0;
            valid_bytes_d = 8'h00;
            err_d         = blk_err;
            if (!blk_err) begin
                unique case (kind)
                    K_START: begin
                        data_out_d    = {payload, 8'h00};
                        valid_bytes_d = 8'hFE;
                    end
                    K_DATA: begin
                        data_out_d    = bus.block_in[65:2];
                        valid_bytes_d = 8'hFF;
                    end
                    K_TERM: begin
                        for (int k = 0; k < 7; k++) begin
                            if (4'(k) < term_n) begin
                                data_out_d[8*k +: 8] = payload[8*k +: 8];
                            end
                        end
                        valid_bytes_d = 8'hFF >> (4'd8 - term_n);
                    end
                    default: begin
                        data_out_d    = '0;
                        valid_bytes_d = 8'h00;
                    end
                endcase
            end
        end

        // Clear wins over a same-cycle increment and is honoured even with en low.
        err_count_d = err_count_q;
        if (bus.clr_count) begin
            err_count_d = '0;
        end else if (bus.en && blk_err && err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.valid_bytes = valid_bytes_q;
    assign bus.err         = err_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_block_decoder.sv
// Self-checking bench for block_decoder: a table-driven frame model checked every cycle,
// plus directed blocks with hand-computed literal expectations.
module tb_block_decoder;
    localparam int W = 16;

    logic clk;
    logic reset;

    block_decoder_if #(.ERR_CNT_W(W)) bus ();

    block_decoder #(.ERR_CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        in_frame;
        logic [63:0] d;
        logic [7:0]  v;
        logic        e;
    } step_t;

    function automatic step_t model(input logic [65:0] b, input logic in_frame);
        step_t       r;
        int          n;
        logic [55:0] p;
        p = b[65:10];
        n = -1;
        r.in_frame = in_frame;
        r.d = '0;
        r.v = '0;
        r.e = 1'b0;
        if (b[1:0] == 2'b10) begin
            if (in_frame) begin
                r.d = b[65:2];
                r.v = 8'hFF;
            end else begin
                r.e = 1'b1;
            end
        end else if (b[1:0] == 2'b01) begin
            case (b[9:2])
                8'h78: ;
                8'h1E: begin
                    if (!in_frame) begin
                        r.d = {p, 8'h00};
                        r.v = 8'hFE;
                        r.in_frame = 1'b1;
                    end else begin
                        r.e = 1'b1;
                    end
                end
                8'hE1: n = 0;
                8'h99: n = 1;
                8'h55: n = 2;
                8'h2D: n = 3;
                8'h33: n = 4;
                8'h4B: n = 5;
                8'h87: n = 6;
                8'hFF: n = 7;
                default: r.e = 1'b1;
            endcase
            if (n >= 0) begin
                if (in_frame) begin
                    r.d = {8'h00, p} & ((64'h1 << (8 * n)) - 64'h1);
                    r.v = 8'((1 << n) - 1);
                    r.in_frame = 1'b0;
                end else begin
                    r.e = 1'b1;
                end
            end
        end else begin
            r.e = 1'b1;
        end
        if (r.e) begin
            r.d = '0;
            r.v = '0;
            r.in_frame = 1'b0;
        end
        return r;
    endfunction

    logic         m_frame;
    logic [63:0]  m_d;
    logic [7:0]   m_v;
    logic         m_e;
    logic [W-1:0] m_cnt;
    step_t        s;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_frame <= 1'b0;
            m_d     <= '0;
            m_v     <= '0;
            m_e     <= 1'b0;
            m_cnt   <= '0;
        end else begin
            s = model(bus.block_in, m_frame);
            if (bus.en) begin
                m_frame <= s.in_frame;
                m_d     <= s.d;
                m_v     <= s.v;
                m_e     <= s.e;
            end
            if (bus.clr_count) m_cnt <= '0;
            else if (bus.en && s.e && m_cnt != {W{1'b1}}) m_cnt <= m_cnt + 1'b1;
        end
    end

    // ---------------- literal expectation requests ----------------
    int           req_seq = 0;
    string        l_nm;
    logic [7:0]   l_v;
    logic [63:0]  l_d;
    logic         l_e;
    logic [W-1:0] l_c;

    // Called right after drive(): the result for that block is checked one cycle later.
    task automatic lit(input string nm, input logic [7:0] v, input logic [63:0] d,
                       input logic e, input logic [W-1:0] c);
        l_nm = nm;
        l_v  = v;
        l_d  = d;
        l_e  = e;
        l_c  = c;
        req_seq++;
    endtask

    // ---------------- compare process ----------------
    int           seen_seq = 0;
    bit           pend = 1'b0;
    string        p_nm;
    logic [7:0]   p_v;
    logic [63:0]  p_d;
    logic         p_e;
    logic [W-1:0] p_c;

    always @(negedge clk) begin
        if (!reset) begin
            check("model_data_out",    bus.data_out,    m_d);
            check("model_valid_bytes", 64'(bus.valid_bytes), 64'(m_v));
            check("model_err",         64'(bus.err),    64'(m_e));
            check("model_err_count",   64'(bus.err_count), 64'(m_cnt));
            if (pend) begin
                check({p_nm, "_valid"}, 64'(bus.valid_bytes), 64'(p_v));
                check({p_nm, "_data"},  bus.data_out, p_d);
                check({p_nm, "_err"},   64'(bus.err), 64'(p_e));
                check({p_nm, "_cnt"},   64'(bus.err_count), 64'(p_c));
                pend = 1'b0;
            end
            if (req_seq != seen_seq) begin
                seen_seq = req_seq;
                p_nm = l_nm;
                p_v  = l_v;
                p_d  = l_d;
                p_e  = l_e;
                p_c  = l_c;
                pend = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [65:0] ctrl(input logic [7:0] t, input logic [55:0] p);
        return {p, t, 2'b01};
    endfunction

    function automatic logic [65:0] dblk(input logic [63:0] d);
        return {d, 2'b10};
    endfunction

    task automatic drive(input logic [65:0] b, input logic e, input logic clr);
        @(posedge clk);
        #1;
        bus.block_in  = b;
        bus.en        = e;
        bus.clr_count = clr;
    endtask

    localparam logic [63:0] DPAT = 64'hFFEEDDCCBBAA9988;
    localparam logic [55:0] TPAY = 56'h77665544332211;

    logic [7:0]  term_type [8] = '{8'hE1, 8'h99, 8'h55, 8'h2D, 8'h33, 8'h4B, 8'h87, 8'hFF};
    logic [7:0]  term_v    [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
    logic [63:0] term_d    [8] = '{64'h0, 64'h11, 64'h2211, 64'h332211, 64'h44332211,
                                   64'h5544332211, 64'h665544332211, 64'h77665544332211};

    initial begin
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.block_in  = '0;
        bus.clr_count = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values with en low
        drive(ctrl(8'h78, '0), 1'b0, 1'b0);
        lit("reset", 8'h00, 64'h0, 1'b0, 16'd0);

        for (int i = 0; i < 4; i++) begin
            drive(ctrl(8'h78, 56'h0), 1'b1, 1'b0);
            lit("idle", 8'h00, 64'h0, 1'b0, 16'd0);
        end

        // One full frame
        drive(ctrl(8'h1E, 56'h07060504030201), 1'b1, 1'b0);
        lit("start", 8'hFE, 64'h0706050403020100, 1'b0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            drive(dblk(DPAT), 1'b1, 1'b0);
            lit("data", 8'hFF, DPAT, 1'b0, 16'd0);
        end
        drive(ctrl(8'h2D, 56'hABCDEF12332211), 1'b1, 1'b0);
        lit("term3", 8'h07, 64'h0000000000332211, 1'b0, 16'd0);

        // Data block in IDLE
        drive(dblk(DPAT), 1'b1, 1'b0);
        lit("data_in_idle", 8'h00, 64'h0, 1'b1, 16'd1);

        // Terminate sweep
        for (int i = 0; i < 8; i++) begin
            drive(ctrl(8'h1E, 56'h0), 1'b1, 1'b0);
            drive(ctrl(term_type[i], TPAY), 1'b1, 1'b0);
            lit($sformatf("term_sweep%0d", i), term_v[i], term_d[i], 1'b0, 16'd1);
        end
        drive(dblk(DPAT), 1'b1, 1'b0);
        lit("data_after_term", 8'h00, 64'h0, 1'b1, 16'd2);

        // Terminate in IDLE
        drive(ctrl(8'h55, TPAY), 1'b1, 1'b0);
        lit("term_in_idle", 8'h00, 64'h0, 1'b1, 16'd3);

        // Bad sync header mid-frame
        drive(ctrl(8'h1E, 56'h0), 1'b1, 1'b0);
        drive(dblk(DPAT), 1'b1, 1'b0);
        drive({DPAT, 2'b11}, 1'b1, 1'b0);
        lit("bad_sync", 8'h00, 64'h0, 1'b1, 16'd4);
        drive(dblk(DPAT), 1'b1, 1'b0);
        lit("data_after_bad_sync", 8'h00, 64'h0, 1'b1, 16'd5);

        // Start while in DATA, then unknown type
        drive(ctrl(8'h1E, 56'h0), 1'b1, 1'b0);
        drive(ctrl(8'h1E, 56'h0), 1'b1, 1'b0);
        lit("start_in_data", 8'h00, 64'h0, 1'b1, 16'd6);
        drive(dblk(DPAT), 1'b1, 1'b0);
        lit("data_after_dup_start", 8'h00, 64'h0, 1'b1, 16'd7);
        drive(ctrl(8'h42, 56'h0), 1'b1, 1'b0);
        lit("unknown_type", 8'h00, 64'h0, 1'b1, 16'd8);

        // en low holds outputs
        drive(ctrl(8'h1E, 56'h11223344556677), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive({DPAT, 2'b00}, 1'b0, 1'b0);
            lit("en_hold", 8'hFE, 64'h1122334455667700, 1'b0, 16'd8);
        end

        // clr_count honoured with en low
        drive(dblk(DPAT), 1'b0, 1'b1);
        lit("clr_en_low", 8'hFE, 64'h1122334455667700, 1'b0, 16'd0);

        // Reset mid-frame: state is DATA here, next block after reset decodes from IDLE
        drive(dblk(DPAT), 1'b1, 1'b0);
        drive(ctrl(8'h78, 56'h0), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(dblk(DPAT), 1'b1, 1'b0);
        lit("data_after_reset", 8'h00, 64'h0, 1'b1, 16'd1);

        // Saturation: hold an erroring block for more than 2^W cycles
        drive(dblk(DPAT), 1'b1, 1'b0);
        repeat ((1 << W) + 2) @(posedge clk);
        drive(dblk(DPAT), 1'b1, 1'b0);
        lit("saturated", 8'h00, 64'h0, 1'b1, 16'hFFFF);

        // Clear wins over simultaneous increment
        drive(dblk(DPAT), 1'b1, 1'b1);
        lit("clr_with_err", 8'h00, 64'h0, 1'b1, 16'd0);

        drive(ctrl(8'h78, 56'h0), 1'b1, 1'b0);
        lit("final_idle", 8'h00, 64'h0, 1'b0, 16'd0);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
